// File: rtl/freelist_ctrl_if.sv
// Rename/commit side signals of the physical-register free list.
// The slave modport is the free list itself; master is rename + ROB commit.
interface freelist_ctrl_if #(
   parameter int PREG_W = 6,
   parameter int PTR_W  = 6
);
   logic              rn2fl_instr0_lrd_valid;
   logic              rn2fl_instr1_lrd_valid;
   logic [PREG_W-1:0] fl2rn_instr0prd;
   logic [PREG_W-1:0] fl2rn_instr1prd;
   logic              fl2rn_ready;
   logic              rob2fl_commit0_valid;
   logic [PREG_W-1:0] rob2fl_commit0_old_prd;
   logic              rob2fl_commit1_valid;
   logic [PREG_W-1:0] rob2fl_commit1_old_prd;
   logic              flush_valid;
   logic [PTR_W-1:0]  fl_free_count;

   modport slave (
      input  rn2fl_instr0_lrd_valid, rn2fl_instr1_lrd_valid,
      input  rob2fl_commit0_valid, rob2fl_commit0_old_prd,
      input  rob2fl_commit1_valid, rob2fl_commit1_old_prd,
      input  flush_valid,
      output fl2rn_instr0prd, fl2rn_instr1prd, fl2rn_ready, fl_free_count
   );

   modport master (
      output rn2fl_instr0_lrd_valid, rn2fl_instr1_lrd_valid,
      output rob2fl_commit0_valid, rob2fl_commit0_old_prd,
      output rob2fl_commit1_valid, rob2fl_commit1_old_prd,
      output flush_valid,
      input  fl2rn_instr0prd, fl2rn_instr1prd, fl2rn_ready, fl_free_count
   );
endinterface

// File: rtl/freelist_ctrl.sv
// Dual-ported physical-register free list: circular buffer with speculative head,
// architectural head for one-cycle flush recovery, and a release tail.
module freelist_ctrl #(
   parameter int PREG_NUM = 64,
   parameter int LREG_NUM = 32,
   parameter int PREG_W   = 6,
   parameter int PTR_W    = 6
) (
   input logic            clock,
   input logic            reset_n,
   freelist_ctrl_if.slave fl_if
);
   localparam int FL_DEPTH = PREG_NUM - LREG_NUM;
   localparam int IDX_W    = PTR_W - 1;

   logic [PREG_W-1:0] entry_q [FL_DEPTH];
   logic [PREG_W-1:0] entry_d [FL_DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  arch_head_q, arch_head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;

   logic [PTR_W-1:0]  free_count;
   logic              ready;
   logic [PTR_W-1:0]  n_alloc;
   logic [PTR_W-1:0]  n_commit;
   logic [IDX_W-1:0]  head_idx, head_idx1;
   logic [IDX_W-1:0]  tail_idx, tail_idx1;

   assign free_count = tail_q - head_q;
   assign ready      = free_count >= PTR_W'(2);
   assign head_idx   = head_q[IDX_W-1:0];
   assign head_idx1  = head_idx + IDX_W'(1);
   assign tail_idx   = tail_q[IDX_W-1:0];
   assign tail_idx1  = tail_idx + IDX_W'(1);

   // Grants are read straight from registered state; no release bypass.
   assign fl_if.fl2rn_instr0prd = entry_q[head_idx];
   assign fl_if.fl2rn_instr1prd = fl_if.rn2fl_instr0_lrd_valid ? entry_q[head_idx1]
                                                                : entry_q[head_idx];
   assign fl_if.fl2rn_ready     = ready;
   assign fl_if.fl_free_count   = free_count;

   always_comb begin
      n_commit = PTR_W'(fl_if.rob2fl_commit0_valid) + PTR_W'(fl_if.rob2fl_commit1_valid);
      n_alloc  = '0;
      if (ready && !fl_if.flush_valid)
         n_alloc = PTR_W'(fl_if.rn2fl_instr0_lrd_valid) + PTR_W'(fl_if.rn2fl_instr1_lrd_valid);

      arch_head_d = arch_head_q + n_commit;
      tail_d      = tail_q + n_commit;
      // Flush rewinds to the committed allocation point, including this cycle's commits.
      head_d      = fl_if.flush_valid ? (arch_head_q + n_commit) : (head_q + n_alloc);

      entry_d = entry_q;
      if (fl_if.rob2fl_commit0_valid)
         entry_d[tail_idx] = fl_if.rob2fl_commit0_old_prd;
      if (fl_if.rob2fl_commit1_valid)
         entry_d[fl_if.rob2fl_commit0_valid ? tail_idx1 : tail_idx] = fl_if.rob2fl_commit1_old_prd;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_q      <= '0;
         arch_head_q <= '0;
         tail_q      <= PTR_W'(FL_DEPTH);
         for (int i = 0; i < FL_DEPTH; i++)
            entry_q[i] <= PREG_W'(LREG_NUM + i);
      end else begin
         head_q      <= head_d;
         arch_head_q <= arch_head_d;
         tail_q      <= tail_d;
         entry_q     <= entry_d;
      end
   end

   // Releasing more than was allocated would corrupt the list beyond recovery.
   overflow_a: assert property (@(posedge clock) disable iff (!reset_n)
                                free_count <= PTR_W'(FL_DEPTH))
      else $fatal(1, "freelist_ctrl: free list overflow");
endmodule

// File: tb/tb_freelist_ctrl.sv
// Randomized and directed bench for freelist_ctrl against a queue-based model.
module tb_freelist_ctrl;
   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   freelist_ctrl_if #(.PREG_W(6), .PTR_W(6)) fl_if ();

   freelist_ctrl #(.PREG_NUM(64), .LREG_NUM(32), .PREG_W(6), .PTR_W(6)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .fl_if   (fl_if)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: queue holds every list entry from the committed head onward (always 32),
   // spec = number of those handed out speculatively but not yet committed.
   logic [5:0] fl [$];
   int         spec;

   logic       a_i0, a_i1, a_c0, a_c1, a_fl;
   logic [5:0] a_p0, a_p1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int m_count();
      return fl.size() - spec;
   endfunction

   task automatic model_reset();
      fl.delete();
      for (int i = 0; i < 32; i++) fl.push_back(6'(32 + i));
      spec = 0;
   endtask

   task automatic model_check(input string tag);
      int n;
      n = fl.size();
      check({tag, ".count"}, 32'(fl_if.fl_free_count), 32'(m_count()));
      check({tag, ".ready"}, 32'(fl_if.fl2rn_ready), 32'(m_count() >= 2));
      check({tag, ".grant0"}, 32'(fl_if.fl2rn_instr0prd), 32'(fl[spec % n]));
      check({tag, ".grant1"}, 32'(fl_if.fl2rn_instr1prd),
            32'(a_i0 ? fl[(spec + 1) % n] : fl[spec % n]));
   endtask

   task automatic apply(input logic i0, input logic i1,
                        input logic c0, input logic [5:0] p0,
                        input logic c1, input logic [5:0] p1,
                        input logic f, input string tag);
      a_i0 = i0; a_i1 = i1; a_c0 = c0; a_p0 = p0; a_c1 = c1; a_p1 = p1; a_fl = f;
      fl_if.rn2fl_instr0_lrd_valid = i0;
      fl_if.rn2fl_instr1_lrd_valid = i1;
      fl_if.rob2fl_commit0_valid   = c0;
      fl_if.rob2fl_commit0_old_prd = p0;
      fl_if.rob2fl_commit1_valid   = c1;
      fl_if.rob2fl_commit1_old_prd = p1;
      fl_if.flush_valid            = f;
      #2;
      model_check(tag);
   endtask

   task automatic tick();
      int  n;
      int  na;
      bit  rdy;
      @(posedge clock);
      n   = int'(a_c0) + int'(a_c1);
      na  = int'(a_i0) + int'(a_i1);
      rdy = (m_count() >= 2);
      for (int k = 0; k < n; k++) void'(fl.pop_front());
      if (a_c0) fl.push_back(a_p0);
      if (a_c1) fl.push_back(a_p1);
      spec -= n;
      if (a_fl)     spec = 0;
      else if (rdy) spec += na;
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      a_i0 = 0; a_i1 = 0; a_c0 = 0; a_c1 = 0; a_fl = 0; a_p0 = '0; a_p1 = '0;
      fl_if.rn2fl_instr0_lrd_valid = 1'b0;
      fl_if.rn2fl_instr1_lrd_valid = 1'b0;
      fl_if.rob2fl_commit0_valid   = 1'b0;
      fl_if.rob2fl_commit0_old_prd = '0;
      fl_if.rob2fl_commit1_valid   = 1'b0;
      fl_if.rob2fl_commit1_old_prd = '0;
      fl_if.flush_valid            = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic i0, i1, c0, c1, f;
      do_reset();

      // Reset values
      apply(0, 0, 0, 0, 0, 0, 0, "reset");
      check("reset.count_k", 32'(fl_if.fl_free_count), 32);
      check("reset.ready_k", 32'(fl_if.fl2rn_ready), 1);
      check("reset.prd0_k", 32'(fl_if.fl2rn_instr0prd), 32);
      check("reset.prd1_k", 32'(fl_if.fl2rn_instr1prd), 32);

      // Dual allocation for three cycles
      for (int c = 0; c < 3; c++) begin
         apply(1, 1, 0, 0, 0, 0, 0, "dual");
         check("dual.prd0_k", 32'(fl_if.fl2rn_instr0prd), 32'(32 + 2 * c));
         check("dual.prd1_k", 32'(fl_if.fl2rn_instr1prd), 32'(33 + 2 * c));
         tick();
      end
      apply(0, 0, 0, 0, 0, 0, 0, "dual_end");
      check("dual.count_k", 32'(fl_if.fl_free_count), 26);

      // Instr1-only allocation
      do_reset();
      apply(0, 1, 0, 0, 0, 0, 0, "i1only");
      check("i1only.prd1_k", 32'(fl_if.fl2rn_instr1prd), 32);
      tick();
      apply(1, 0, 0, 0, 0, 0, 0, "i1only_next");
      check("i1only.prd0_k", 32'(fl_if.fl2rn_instr0prd), 33);
      check("i1only.count_k", 32'(fl_if.fl_free_count), 31);
      tick();

      // Exhaustion, dropped requests, release with wrap
      do_reset();
      for (int c = 0; c < 15; c++) begin
         apply(1, 1, 0, 0, 0, 0, 0, "exh");
         tick();
      end
      apply(1, 1, 0, 0, 0, 0, 0, "exh_last");
      check("exh.count2_k", 32'(fl_if.fl_free_count), 2);
      check("exh.ready1_k", 32'(fl_if.fl2rn_ready), 1);
      tick();
      apply(1, 1, 0, 0, 0, 0, 0, "exh_empty");
      check("exh.count0_k", 32'(fl_if.fl_free_count), 0);
      check("exh.ready0_k", 32'(fl_if.fl2rn_ready), 0);
      tick();
      apply(1, 1, 1, 6'd5, 1, 6'd7, 0, "exh_drop");
      check("exh.dropped_k", 32'(fl_if.fl_free_count), 0);
      tick();
      apply(1, 1, 0, 0, 0, 0, 0, "exh_release");
      check("exh.count_rel_k", 32'(fl_if.fl_free_count), 2);
      check("exh.ready_rel_k", 32'(fl_if.fl2rn_ready), 1);
      check("exh.prd0_rel_k", 32'(fl_if.fl2rn_instr0prd), 5);
      check("exh.prd1_rel_k", 32'(fl_if.fl2rn_instr1prd), 7);
      tick();

      // Flush restores head to committed point plus same-cycle commit
      do_reset();
      for (int c = 0; c < 3; c++) begin
         apply(1, 1, 0, 0, 0, 0, 0, "fl_alloc");
         tick();
      end
      apply(0, 0, 1, 6'd1, 1, 6'd2, 0, "fl_commit");
      check("flush.count26_k", 32'(fl_if.fl_free_count), 26);
      tick();
      apply(1, 1, 1, 6'd3, 0, 0, 1, "fl_flush");
      tick();
      apply(0, 0, 0, 0, 0, 0, 0, "fl_after");
      check("flush.count_k", 32'(fl_if.fl_free_count), 32);
      check("flush.prd0_k", 32'(fl_if.fl2rn_instr0prd), 35);
      tick();

      // Asynchronous reset mid-stream
      do_reset();
      for (int c = 0; c < 5; c++) begin
         apply(1, 1, 0, 0, 0, 0, 0, "ar_alloc");
         tick();
      end
      apply(0, 0, 0, 0, 0, 0, 0, "ar_pre");
      reset_n = 1'b0;
      #1;
      check("areset.count_k", 32'(fl_if.fl_free_count), 32);
      check("areset.ready_k", 32'(fl_if.fl2rn_ready), 1);
      check("areset.prd0_k", 32'(fl_if.fl2rn_instr0prd), 32);
      check("areset.prd1_k", 32'(fl_if.fl2rn_instr1prd), 32);
      model_reset();
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      // Random traffic: commits never exceed outstanding speculative allocations
      for (int c = 0; c < 600; c++) begin
         i0 = 1'($urandom_range(0, 1));
         i1 = 1'($urandom_range(0, 1));
         c0 = 1'($urandom_range(0, 1));
         c1 = 1'($urandom_range(0, 1));
         if (spec == 0) begin
            c0 = 1'b0; c1 = 1'b0;
         end else if (spec == 1 && c0 && c1) begin
            c1 = 1'b0;
         end
         f = ($urandom_range(0, 19) == 0);
         apply(i0, i1, c0, 6'($urandom), c1, 6'($urandom), f, "rand");
         tick();
      end
      apply(0, 0, 0, 0, 0, 0, 0, "rand_end");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
